// File: rtl/adder_tree_pipe.sv
// Pipelined unsigned adder tree over NUM packed channels, with optional
// per-group accumulation, wrap/saturate output and a global backpressure stall.
module adder_tree_pipe #(
    parameter int unsigned BITS = 16,
    parameter int unsigned NUM  = 4,
    parameter int unsigned SAT  = 0,
    parameter int unsigned ACC  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    output logic                ready,
    input  logic [NUM*BITS-1:0] data_in,
    input  logic                last,
    output logic [BITS-1:0]     o,
    output logic                overflow,
    output logic                valid_out,
    input  logic                out_ready
);

    localparam int unsigned CLOG = (NUM > 1) ? $clog2(NUM) : 0;
    localparam int unsigned LAT  = (CLOG < 1) ? 1 : CLOG;
    localparam int unsigned SW   = BITS + CLOG;
    localparam int unsigned AW   = SW + 8;

    typedef logic [SW-1:0] sum_t;

    sum_t            lv_c  [LAT][NUM];
    sum_t            lvl_q [LAT][NUM];
    sum_t            lvl_d [LAT][NUM];
    logic [LAT-1:0]  vld_q, vld_d;
    logic [LAT-1:0]  lst_q, lst_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [BITS-1:0] o_q, o_d;
    logic            ovf_q, ovf_d;
    logic            vout_q, vout_d;

    logic            stall_c;
    logic            src_v_c;
    logic            src_last_c;
    sum_t            src_sum_c;
    logic [AW-1:0]   total_c;
    logic            total_ovf_c;

    assign stall_c   = vout_q & ~out_ready;
    assign ready     = ~stall_c;
    assign o         = o_q;
    assign overflow  = ovf_q;
    assign valid_out = vout_q;

    // Operands feeding each tree level: the input channels, then the level registers.
    always_comb begin
        for (int unsigned k = 0; k < NUM; k++) begin
            lv_c[0][k] = SW'(data_in[k*BITS +: BITS]);
        end
        for (int unsigned s = 1; s < LAT; s++) begin
            for (int unsigned k = 0; k < NUM; k++) begin
                lv_c[s][k] = lvl_q[s-1][k];
            end
        end
    end

    // Pairwise reduction: element k folds into slot k/2, so an odd tail passes through.
    always_comb begin
        vld_d = vld_q;
        lst_d = lst_q;
        for (int unsigned s = 0; s < LAT; s++) begin
            for (int unsigned k = 0; k < NUM; k++) begin
                lvl_d[s][k] = lvl_q[s][k];
            end
        end
        if (!stall_c) begin
            for (int unsigned s = 0; s < LAT; s++) begin
                for (int unsigned k = 0; k < NUM; k++) begin
                    lvl_d[s][k] = '0;
                end
                for (int unsigned k = 0; k < NUM; k++) begin
                    lvl_d[s][k>>1] = lvl_d[s][k>>1] + lv_c[s][k];
                end
            end
            vld_d[0] = valid;
            lst_d[0] = last;
            for (int unsigned s = 1; s < LAT; s++) begin
                vld_d[s] = vld_q[s-1];
                lst_d[s] = lst_q[s-1];
            end
        end
    end

    // Output stage: straight off the final adder, or one cycle later via the accumulator.
    always_comb begin
        acc_d       = acc_q;
        o_d         = o_q;
        ovf_d       = ovf_q;
        vout_d      = vout_q;
        src_v_c     = (ACC != 0) ? vld_q[LAT-1] : vld_d[LAT-1];
        src_last_c  = (ACC != 0) ? lst_q[LAT-1] : 1'b1;
        src_sum_c   = (ACC != 0) ? lvl_q[LAT-1][0] : lvl_d[LAT-1][0];
        total_c     = ((ACC != 0) ? acc_q : '0) + AW'(src_sum_c);
        total_ovf_c = |total_c[AW-1:BITS];
        if (!stall_c) begin
            vout_d = 1'b0;
            if (src_v_c) begin
                if (src_last_c) begin
                    vout_d = 1'b1;
                    ovf_d  = total_ovf_c;
                    o_d    = ((SAT != 0) && total_ovf_c) ? '1 : total_c[BITS-1:0];
                    acc_d  = '0;
                end else begin
                    acc_d  = total_c;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < LAT; s++) begin
                for (int unsigned k = 0; k < NUM; k++) begin
                    lvl_q[s][k] <= '0;
                end
            end
            vld_q  <= '0;
            lst_q  <= '0;
            acc_q  <= '0;
            o_q    <= '0;
            ovf_q  <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_d;
            vld_q  <= vld_d;
            lst_q  <= lst_d;
            acc_q  <= acc_d;
            o_q    <= o_d;
            ovf_q  <= ovf_d;
            vout_q <= vout_d;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: wrap/saturate, latency, stall, accumulate,
// mid-flight reset and the NUM=1 / NUM=5 corner configurations.
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    logic reset;
    logic lo, hi;

    // u0: NUM=4 BITS=16 wrap; u1: same beats, saturating
    logic        v0, or0, or1, rdy0, rdy1, ovf0, ovf1, vo0, vo1;
    logic [63:0] d0;
    logic [15:0] o0, o1;
    // u2: NUM=4 BITS=16 accumulate
    logic        v2, l2, rdy2, ovf2, vo2;
    logic [63:0] d2;
    logic [15:0] o2;
    // u3: NUM=5 BITS=8; u4: NUM=1 BITS=8
    logic        v3, rdy3, ovf3, vo3, v4, rdy4, ovf4, vo4;
    logic [39:0] d3;
    logic [7:0]  d4, o3, o4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_tree_pipe #(.BITS(16), .NUM(4), .SAT(0), .ACC(0)) u0 (
        .clk(clk), .reset(reset), .valid(v0), .ready(rdy0), .data_in(d0), .last(lo),
        .o(o0), .overflow(ovf0), .valid_out(vo0), .out_ready(or0));
    adder_tree_pipe #(.BITS(16), .NUM(4), .SAT(1), .ACC(0)) u1 (
        .clk(clk), .reset(reset), .valid(v0), .ready(rdy1), .data_in(d0), .last(lo),
        .o(o1), .overflow(ovf1), .valid_out(vo1), .out_ready(or1));
    adder_tree_pipe #(.BITS(16), .NUM(4), .SAT(0), .ACC(1)) u2 (
        .clk(clk), .reset(reset), .valid(v2), .ready(rdy2), .data_in(d2), .last(l2),
        .o(o2), .overflow(ovf2), .valid_out(vo2), .out_ready(hi));
    adder_tree_pipe #(.BITS(8), .NUM(5), .SAT(0), .ACC(0)) u3 (
        .clk(clk), .reset(reset), .valid(v3), .ready(rdy3), .data_in(d3), .last(lo),
        .o(o3), .overflow(ovf3), .valid_out(vo3), .out_ready(hi));
    adder_tree_pipe #(.BITS(8), .NUM(1), .SAT(0), .ACC(0)) u4 (
        .clk(clk), .reset(reset), .valid(v4), .ready(rdy4), .data_in(d4), .last(lo),
        .o(o4), .overflow(ovf4), .valid_out(vo4), .out_ready(hi));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One accumulation group of nb identical beats, last on the final one.
    task automatic acc_group(input string tag, input int nb, input logic [63:0] d,
                             input logic [15:0] exp_o);
        int          seen = 0;
        int          at   = -1;
        logic [15:0] got  = '0;
        for (int i = 0; i < nb + 6; i++) begin
            @(negedge clk);
            if (vo2) begin
                seen++;
                at  = i;
                got = o2;
            end
            if (i < nb) begin
                v2 = 1'b1; d2 = d; l2 = (i == nb - 1);
            end else begin
                v2 = 1'b0; l2 = 1'b0;
            end
        end
        check({tag, "_count"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(at), 32'(nb + 2));
        check({tag, "_o"}, 32'(got), 32'(exp_o));
    endtask

    logic [63:0] sb [4];
    logic [15:0] se [4];

    initial begin
        int bi, ri, low, spur;
        logic started;

        sb[0] = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; se[0] = 16'h000A;
        sb[1] = {4{16'h0100}};                            se[1] = 16'h0400;
        sb[2] = {16'h0000, 16'h0001, 16'h8000, 16'h8000}; se[2] = 16'h0001;
        sb[3] = {16'h0000, 16'h0000, 16'h0000, 16'h1234}; se[3] = 16'h1234;

        reset = 1'b1; lo = 1'b0; hi = 1'b1;
        v0 = 0; d0 = '0; or0 = 1; or1 = 1;
        v2 = 0; d2 = '0; l2 = 0;
        v3 = 0; d3 = '0; v4 = 0; d4 = '0;

        // Reset state
        @(negedge clk);
        check("rst_ready0", 32'(rdy0), 1);
        check("rst_vo0", 32'(vo0), 0);
        check("rst_o0", 32'(o0), 0);
        check("rst_ovf0", 32'(ovf0), 0);
        check("rst_vo2", 32'(vo2), 0);
        check("rst_ready4", 32'(rdy4), 1);

        // First beat right at reset release; latency 2 / 3 / 1
        reset = 1'b0;
        v0 = 1; d0 = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        v3 = 1; d3 = {5{8'h40}};
        v4 = 1; d4 = 8'hC3;
        @(negedge clk);
        v0 = 0; v3 = 0; v4 = 0;
        check("lat_u0_early", 32'(vo0), 0);
        check("lat_u4_vo", 32'(vo4), 1);
        check("lat_u4_o", 32'(o4), 32'h00C3);
        check("lat_u4_ovf", 32'(ovf4), 0);
        check("lat_u3_early", 32'(vo3), 0);
        @(negedge clk);
        check("sum_vo0", 32'(vo0), 1);
        check("sum_o0", 32'(o0), 32'hA000);
        check("sum_ovf0", 32'(ovf0), 0);
        check("sum_o1_sat", 32'(o1), 32'hA000);
        check("lat_u4_drop", 32'(vo4), 0);
        check("lat_u3_mid", 32'(vo3), 0);
        @(negedge clk);
        check("n5_vo3", 32'(vo3), 1);
        check("n5_o3", 32'(o3), 32'h40);
        check("n5_ovf3", 32'(ovf3), 1);
        check("sum_drop0", 32'(vo0), 0);

        // All-ones: wrap vs saturate
        v0 = 1; d0 = {4{16'hFFFF}};
        @(negedge clk);
        v0 = 0;
        @(negedge clk);
        check("ff_vo0", 32'(vo0), 1);
        check("ff_o0", 32'(o0), 32'hFFFC);
        check("ff_ovf0", 32'(ovf0), 1);
        check("ff_o1", 32'(o1), 32'hFFFF);
        check("ff_ovf1", 32'(ovf1), 1);
        @(negedge clk);
        check("ff_drop0", 32'(vo0), 0);

        // Back-to-back beats with out_ready low for three cycles
        bi = 0; ri = 0; low = 0; started = 1'b0;
        for (int c = 0; c < 30 && ri < 4; c++) begin
            @(negedge clk);
            if (vo0) begin
                check("stall_o", 32'(o0), 32'(se[ri]));
                started = 1'b1;
            end
            or0 = !(started && low < 3);
            if (!or0) low++;
            if (bi < 4) begin
                v0 = 1; d0 = sb[bi];
            end else begin
                v0 = 0;
            end
            #1;
            if (!or0) check("stall_ready", 32'(rdy0), 0);
            if (vo0 && or0) ri++;
            if (v0 && rdy0) bi++;
        end
        v0 = 0; or0 = 1;
        check("stall_accepted", 32'(bi), 4);
        check("stall_delivered", 32'(ri), 4);
        check("stall_low_cycles", 32'(low), 3);
        @(negedge clk);
        check("stall_nodup", 32'(vo0), 0);

        // Accumulation groups
        acc_group("acc_g1", 3, {4{16'h0004}}, 16'h0030);
        acc_group("acc_g2", 1, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h000A);

        // Reset with beats in flight and a partial accumulation pending
        @(negedge clk);
        v2 = 1; l2 = 0; d2 = {4{16'h0100}};
        v3 = 1; d3 = {5{8'h01}};
        @(negedge clk);
        v2 = 0; d3 = {5{8'h02}};
        @(negedge clk);
        v3 = 0; reset = 1'b1;
        #1;
        check("rmid_vo3", 32'(vo3), 0);
        check("rmid_o3", 32'(o3), 0);
        check("rmid_o2", 32'(o2), 0);
        check("rmid_ready3", 32'(rdy3), 1);
        @(negedge clk);
        reset = 1'b0;
        spur = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vo2 || vo3) spur++;
        end
        check("rmid_spurious", 32'(spur), 0);
        v2 = 1; l2 = 1; d2 = {4{16'h0001}};
        v3 = 1; d3 = {5{8'h03}};
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            v2 = 0; l2 = 0; v3 = 0;
        end
        check("rpost_vo3", 32'(vo3), 1);
        check("rpost_o3", 32'(o3), 32'h0F);
        check("rpost_ovf3", 32'(ovf3), 0);
        check("rpost_vo2", 32'(vo2), 1);
        check("rpost_o2", 32'(o2), 32'h0004);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 Parameter BITS, default 16, width of each input channel and of output o.
REQ-002 Parameter NUM, default 4, number of input channels, legal range 1..32.
REQ-003 Parameter SAT, default 0: 0 = wrap output to BITS, 1 = saturate unsigned to 2^BITS-1.
REQ-004 Parameter ACC, default 0: 0 = one sum per input beat, 1 = accumulate beats until last.
REQ-005 Derived constant LAT = max(1, ceil(log2 NUM)), pipeline latency in cycles.
REQ-006 clk  input  1  sole clock, all state on posedge clk.
REQ-007 reset  input  1  reset, asynchronous and active-high.
REQ-008 valid  input  1  input beat present.
REQ-009 ready  output  1  block accepts a beat this cycle.
REQ-010 data_in  input  NUM*BITS  packed channels, channel k at bits [k*BITS +: BITS].
REQ-011 last  input  1  final beat of an accumulation group, ignored when ACC=0.
REQ-012 o  output  BITS  result.
REQ-013 overflow  output  1  result exceeded BITS and was wrapped or saturated, qualified by valid_out.
REQ-014 valid_out  output  1  o and overflow valid.
REQ-015 out_ready  input  1  downstream accepts result.

Function
REQ-016 Beat accepted when valid && ready; result transferred when valid_out && out_ready.
REQ-017 stall = valid_out && !out_ready; ready SHALL equal !stall, combinationally.
REQ-018 While stall, every pipeline register, o, overflow and valid_out SHALL hold their values; no beat lost or duplicated.
REQ-019 Adder tree: unsigned, level i sums pairs of level i-1, odd element passed through, one register per level.
REQ-020 Internal sum width SHALL be BITS+ceil(log2 NUM) with no loss of carry; NUM=1 is a single register stage.
REQ-021 ACC=0: an accepted beat at cycle t SHALL appear on o with valid_out at cycle t+LAT, absent stalls.
REQ-022 ACC=1: accumulator of width BITS+ceil(log2 NUM)+8 adds each tree result; no valid_out for non-last beats.
REQ-023 ACC=1: on the last beat, valid_out rises with (accumulator + that beat's sum) one cycle after it exits the tree; accumulator then clears to 0.
REQ-024 ACC=1: first beat after reset or after a last beat SHALL start from accumulator 0.
REQ-025 Output rule: overflow = (full sum >= 2^BITS); o = full sum[BITS-1:0] if SAT=0, else 2^BITS-1 when overflow.
REQ-026 Back-to-back beats accepted every cycle with out_ready high give full throughput, one result per cycle (ACC=0).
REQ-027 valid_out low SHALL not be affected by out_ready; bubble beats propagate as invalid stages.

Reset
REQ-028 reset high SHALL immediately clear all stage valid bits, valid_out, overflow, o and accumulator to 0.
REQ-029 reset asserted mid-operation SHALL discard all in-flight beats and partial accumulation; no result after release.
REQ-030 ready SHALL be 1 during and after reset (valid_out is 0).
REQ-031 First beat is accepted on the first posedge clk with reset low.

Verification
REQ-032 NUM=4, BITS=16: data_in channels 0x1000,0x2000,0x3000,0x4000 -> o=0xA000, overflow=0, valid_out exactly 2 cycles after accept.
REQ-033 NUM=4, all channels 0xFFFF: SAT=0 -> o=0xFFFC, overflow=1; SAT=1 -> o=0xFFFF, overflow=1.
REQ-034 Four back-to-back beats, out_ready low 3 cycles once first result valid -> ready low those cycles, o held, all four results delivered in order.
REQ-035 ACC=1, NUM=4: three beats each channels 0x0004, last on third -> single valid_out, o=0x0030, next group starts from 0.
REQ-036 reset pulsed while two beats in flight -> valid_out stays 0, o=0, next beat after release yields its own sum only.
REQ-037 NUM=1 and NUM=5 (BITS=8): 5 channels 0x40 -> o=0x40, overflow=1 (SAT=0), latency 3; NUM=1 latency 1.
